// File: rtl/mem_arb_pkg.sv
// Shared types and codes for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      ERR    = 2'b10,
      RESP   = 2'b11
   } arb_state_t;

   typedef enum logic {
      PORT_DATA = 1'b0,
      PORT_IF   = 1'b1
   } port_id_t;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

endpackage

// File: rtl/mem_range_check.sv
// Combinational address window / alignment / size legality check.
module mem_range_check
   import mem_arb_pkg::*;
#(
   parameter int unsigned             ADDRESS_SIZE  = 32,
   parameter int unsigned             ACCESS_SIZE   = 2,
   parameter int unsigned             MEM_SIZE      = 1048578,
   parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000
)(
   input  logic [ADDRESS_SIZE-1:0] addr,
   input  logic [ACCESS_SIZE-1:0]  size,
   output logic                    valid
);

   localparam logic [ADDRESS_SIZE-1:0] MAX_OFFSET = ADDRESS_SIZE'(MEM_SIZE - 4);

   logic [ADDRESS_SIZE-1:0] offset;
   logic                    in_range;
   logic                    aligned;

   // Base address itself is outside the window (strict compare).
   always_comb begin
      offset   = addr - START_ADDRESS;
      in_range = (addr > START_ADDRESS) && (offset <= MAX_OFFSET);
      case (size)
         SZ_BYTE: aligned = 1'b1;
         SZ_HALF: aligned = ~addr[0];
         SZ_WORD: aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
      valid = in_range && aligned;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned             ADDRESS_SIZE  = 32,
   parameter int unsigned             DATA_SIZE     = 32,
   parameter int unsigned             ACCESS_SIZE   = 2,
   parameter int unsigned             MEM_SIZE      = 1048578,
   parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    if_req,
   input  logic [ADDRESS_SIZE-1:0] if_addr,
   output logic                    if_ack,
   output logic [DATA_SIZE-1:0]    if_rdata,
   output logic                    if_err,
   input  logic                    d_req,
   input  logic                    d_wren,
   input  logic [ADDRESS_SIZE-1:0] d_addr,
   input  logic [ACCESS_SIZE-1:0]  d_size,
   input  logic [DATA_SIZE-1:0]    d_wdata,
   output logic                    d_ack,
   output logic [DATA_SIZE-1:0]    d_rdata,
   output logic                    d_err,
   output logic [ADDRESS_SIZE-1:0] mem_addr,
   output logic [DATA_SIZE-1:0]    mem_d_in,
   output logic [ACCESS_SIZE-1:0]  mem_acc_size,
   output logic                    mem_wren,
   output logic                    mem_en,
   input  logic [DATA_SIZE-1:0]    mem_d_out,
   input  logic                    mem_busy
);

   arb_state_t state, state_next;

   // lat_port doubles as the round-robin pointer and the port being served.
   port_id_t                lat_port;
   logic [ADDRESS_SIZE-1:0] lat_addr;
   logic [ACCESS_SIZE-1:0]  lat_size;
   logic [DATA_SIZE-1:0]    lat_wdata;
   logic                    lat_wren;
   logic [DATA_SIZE-1:0]    rdata_q;
   logic                    err_q;

   logic                    sampling;
   logic                    elig_d;
   logic                    elig_if;
   logic                    grant;
   port_id_t                sel_port;
   logic [ADDRESS_SIZE-1:0] sel_addr;
   logic [ACCESS_SIZE-1:0]  sel_size;
   logic [DATA_SIZE-1:0]    sel_wdata;
   logic                    sel_wren;
   logic                    sel_valid;
   logic [DATA_SIZE-1:0]    load_data;

   // Arbitration: the port currently being acked cannot win again in RESP.
   always_comb begin
      sampling = (state == IDLE) || (state == RESP);
      elig_d   = d_req  && !((state == RESP) && (lat_port == PORT_DATA));
      elig_if  = if_req && !((state == RESP) && (lat_port == PORT_IF));
      grant    = sampling && (elig_d || elig_if);
      if (elig_d && elig_if)
         sel_port = (lat_port == PORT_DATA) ? PORT_IF : PORT_DATA;
      else if (elig_if)
         sel_port = PORT_IF;
      else
         sel_port = PORT_DATA;
      if (sel_port == PORT_IF) begin
         sel_addr  = if_addr;
         sel_size  = SZ_WORD;
         sel_wdata = '0;
         sel_wren  = 1'b0;
      end else begin
         sel_addr  = d_addr;
         sel_size  = d_size;
         sel_wdata = d_wdata;
         sel_wren  = d_wren;
      end
   end

   mem_range_check #(
      .ADDRESS_SIZE  (ADDRESS_SIZE),
      .ACCESS_SIZE   (ACCESS_SIZE),
      .MEM_SIZE      (MEM_SIZE),
      .START_ADDRESS (START_ADDRESS)
   ) u_range_check (
      .addr  (sel_addr),
      .size  (sel_size),
      .valid (sel_valid)
   );

   // Sub-word loads come from the MSB-aligned lanes, zero-extended.
   always_comb begin
      load_data = '0;
      case (lat_size)
         SZ_BYTE: load_data[7:0]  = mem_d_out[DATA_SIZE-1 -: 8];
         SZ_HALF: load_data[15:0] = mem_d_out[DATA_SIZE-1 -: 16];
         default: load_data       = mem_d_out;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, RESP: begin
            if (grant) state_next = sel_valid ? ACCESS : ERR;
            else       state_next = IDLE;
         end
         ACCESS:  if (!mem_busy) state_next = RESP;
         ERR:     state_next = RESP;
         default: state_next = IDLE;
      endcase
   end

   // Request latch at grant and response capture at the end of ACCESS/ERR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_port  <= PORT_IF;
         lat_addr  <= '0;
         lat_size  <= '0;
         lat_wdata <= '0;
         lat_wren  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (grant) begin
            lat_port  <= sel_port;
            lat_addr  <= sel_addr;
            lat_size  <= sel_size;
            lat_wdata <= sel_wdata;
            lat_wren  <= sel_wren;
         end
         if ((state == ACCESS) && !mem_busy) begin
            rdata_q <= lat_wren ? '0 : load_data;
            err_q   <= 1'b0;
         end else if (state == ERR) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   // Outputs: memory strobes only in ACCESS, ack/data only in RESP for the winner.
   always_comb begin
      mem_en       = (state == ACCESS);
      mem_wren     = mem_en && lat_wren;
      mem_addr     = mem_en ? lat_addr  : '0;
      mem_d_in     = mem_en ? lat_wdata : '0;
      mem_acc_size = mem_en ? lat_size  : '0;
      if_ack       = (state == RESP) && (lat_port == PORT_IF);
      d_ack        = (state == RESP) && (lat_port == PORT_DATA);
      if_rdata     = if_ack ? rdata_q : '0;
      if_err       = if_ack && err_q;
      d_rdata      = d_ack  ? rdata_q : '0;
      d_err        = d_ack  && err_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small memory model.
module tb_mem_port_arbiter;

   localparam logic [31:0] START = 32'h80020000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req;
   logic        d_wren;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_d_in;
   logic [1:0]  mem_acc_size;
   logic        mem_wren;
   logic        mem_en;
   logic [31:0] mem_d_out;
   logic        mem_busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [0:15];
   logic        mem_init;
   int unsigned en_cycles = 0;

   mem_port_arbiter #(
      .ADDRESS_SIZE  (32),
      .DATA_SIZE     (32),
      .ACCESS_SIZE   (2),
      .MEM_SIZE      (1048578),
      .START_ADDRESS (32'h80020000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_ack       (if_ack),
      .if_rdata     (if_rdata),
      .if_err       (if_err),
      .d_req        (d_req),
      .d_wren       (d_wren),
      .d_addr       (d_addr),
      .d_size       (d_size),
      .d_wdata      (d_wdata),
      .d_ack        (d_ack),
      .d_rdata      (d_rdata),
      .d_err        (d_err),
      .mem_addr     (mem_addr),
      .mem_d_in     (mem_d_in),
      .mem_acc_size (mem_acc_size),
      .mem_wren     (mem_wren),
      .mem_en       (mem_en),
      .mem_d_out    (mem_d_out),
      .mem_busy     (mem_busy)
   );

   always #5 clk = ~clk;

   function automatic int unsigned widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - START;
      return int'(off >> 2);
   endfunction

   // Memory model: preload while mem_init, write on posedge, read on negedge.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h11223344;
         mem[1] <= 32'hDEADBEEF;
         mem[2] <= 32'h0BADF00D;
      end else if (mem_en && mem_wren && widx(mem_addr) < 16) begin
         mem[widx(mem_addr)] <= mem_d_in;
      end
   end

   always @(negedge clk) begin
      if (mem_en) begin
         if (widx(mem_addr) == 32'h3FFFF) mem_d_out <= 32'hCAFEF00D;
         else if (widx(mem_addr) < 16)    mem_d_out <= mem[widx(mem_addr)];
         else                             mem_d_out <= 32'h0;
      end
   end

   always @(posedge clk) if (mem_en) en_cycles <= en_cycles + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction on either port; lat counts cycles from request to ack, 0 on timeout.
   task automatic txn(input bit use_if, input logic wren, input logic [31:0] addr,
                      input logic [1:0] size, input logic [31:0] wdata,
                      output int lat, output logic [31:0] rdata, output logic err);
      bit done;
      lat   = 0;
      rdata = '0;
      err   = 1'b0;
      done  = 1'b0;
      if (use_if) begin
         if_addr = addr;
         if_req  = 1'b1;
      end else begin
         d_addr  = addr;
         d_size  = size;
         d_wren  = wren;
         d_wdata = wdata;
         d_req   = 1'b1;
      end
      for (int i = 1; i <= 20 && !done; i++) begin
         tick();
         if (use_if ? if_ack : d_ack) begin
            lat   = i;
            rdata = use_if ? if_rdata : d_rdata;
            err   = use_if ? if_err : d_err;
            done  = 1'b1;
         end
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      d_wren = 1'b0;
      tick();
   endtask

   int          lat;
   logic [31:0] rd;
   logic        er;
   int unsigned en_before;
   int          nack;
   int          both;
   int          ord  [4];
   int          when [4];
   logic [31:0] rdv  [4];
   bit          stable;
   int          acks;

   initial begin
      rst_n    = 1'b0;
      mem_init = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      d_req    = 1'b0;
      d_wren   = 1'b0;
      d_addr   = '0;
      d_size   = '0;
      d_wdata  = '0;
      mem_busy = 1'b0;
      repeat (3) tick();
      check("rst_ctrl", {30'b0, if_ack, d_ack} | {31'b0, mem_en} | {31'b0, mem_wren}, 32'h0);
      check("rst_data", if_rdata | d_rdata | mem_addr | mem_d_in, 32'h0);
      rst_n    = 1'b1;
      mem_init = 1'b0;
      tick();

      // Single word load
      txn(1'b0, 1'b0, 32'h80020004, 2'b10, 32'h0, lat, rd, er);
      check("ld_lat", lat, 32'd2);
      check("ld_data", rd, 32'hDEADBEEF);
      check("ld_err", {31'b0, er}, 32'h0);

      // Sub-word loads from MSB lanes, including the last legal halfword
      txn(1'b0, 1'b0, 32'h80020005, 2'b00, 32'h0, lat, rd, er);
      check("ldb_data", rd, 32'h000000DE);
      txn(1'b0, 1'b0, 32'h80020001, 2'b00, 32'h0, lat, rd, er);
      check("ldb0_data", rd, 32'h00000011);
      txn(1'b0, 1'b0, 32'h8011FFFE, 2'b01, 32'h0, lat, rd, er);
      check("ldh_top_data", rd, 32'h0000CAFE);
      check("ldh_top_err", {31'b0, er}, 32'h0);

      // Store then fetch same address
      txn(1'b0, 1'b1, 32'h80020010, 2'b10, 32'h12345678, lat, rd, er);
      check("st_lat", lat, 32'd2);
      check("st_rdata", rd, 32'h0);
      check("st_mem", mem[4], 32'h12345678);
      txn(1'b1, 1'b0, 32'h80020010, 2'b10, 32'h0, lat, rd, er);
      check("if_lat", lat, 32'd2);
      check("if_data", rd, 32'h12345678);

      // Contention: both held, expect DATA, IF, DATA, IF every two cycles
      d_addr = 32'h80020004; d_size = 2'b10; d_wren = 1'b0;
      if_addr = 32'h80020010;
      d_req = 1'b1; if_req = 1'b1;
      nack = 0; both = 0;
      for (int i = 1; i <= 16 && nack < 4; i++) begin
         tick();
         if (d_ack && if_ack) both++;
         if (d_ack || if_ack) begin
            ord[nack]  = if_ack ? 1 : 0;
            when[nack] = i;
            rdv[nack]  = if_ack ? if_rdata : d_rdata;
            nack++;
            if (nack == 4) begin d_req = 1'b0; if_req = 1'b0; end
         end
      end
      d_req = 1'b0; if_req = 1'b0;
      tick();
      check("rr_count", nack, 32'd4);
      check("rr_double", both, 32'd0);
      for (int k = 0; k < nack; k++) begin
         check("rr_port", ord[k], k % 2);
         check("rr_cycle", when[k], 2 * (k + 1));
         check("rr_data", rdv[k], (k % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
      end

      // Error cases: no memory strobe, err with zero data
      en_before = en_cycles;
      txn(1'b0, 1'b0, 32'h80020000, 2'b10, 32'h0, lat, rd, er);
      check("e_base_err", {31'b0, er}, 32'h1);
      check("e_base_lat", lat, 32'd2);
      check("e_base_data", rd, 32'h0);
      txn(1'b0, 1'b0, 32'h80020006, 2'b10, 32'h0, lat, rd, er);
      check("e_align_err", {31'b0, er}, 32'h1);
      txn(1'b0, 1'b0, 32'h80020008, 2'b11, 32'h0, lat, rd, er);
      check("e_size_err", {31'b0, er}, 32'h1);
      check("e_size_data", rd, 32'h0);
      txn(1'b0, 1'b0, 32'h8011FFFF, 2'b00, 32'h0, lat, rd, er);
      check("e_top_err", {31'b0, er}, 32'h1);
      txn(1'b1, 1'b0, 32'h80020012, 2'b10, 32'h0, lat, rd, er);
      check("e_if_err", {31'b0, er}, 32'h1);
      check("e_no_mem_en", en_cycles, en_before);

      // Stall: busy for three edges during ACCESS
      d_addr = 32'h80020008; d_size = 2'b10; d_wren = 1'b0; d_req = 1'b1;
      tick();
      check("stall_en", {31'b0, mem_en}, 32'h1);
      mem_busy = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (!mem_en || mem_addr != 32'h80020008 || mem_acc_size != 2'b10 || d_ack) stable = 1'b0;
      end
      mem_busy = 1'b0;
      check("stall_hold", {31'b0, stable}, 32'h1);
      lat = 0;
      for (int i = 5; i <= 20 && lat == 0; i++) begin
         tick();
         if (d_ack) begin lat = i; rd = d_rdata; end
      end
      d_req = 1'b0;
      tick();
      check("stall_lat", lat, 32'd5);
      check("stall_data", rd, 32'h0BADF00D);

      // Reset during a store's ACCESS: abort, no ack, memory untouched
      d_addr = 32'h80020010; d_size = 2'b10; d_wren = 1'b1; d_wdata = 32'hFFFFFFFF; d_req = 1'b1;
      tick();
      check("rstm_pre_en", {31'b0, mem_en}, 32'h1);
      rst_n = 1'b0;
      d_req = 1'b0; d_wren = 1'b0;
      #1;
      check("rstm_outs", {28'b0, if_ack, d_ack, mem_en, mem_wren} | mem_addr | d_rdata, 32'h0);
      acks = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (d_ack || if_ack) acks++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (d_ack || if_ack) acks++;
      end
      check("rstm_no_ack", acks, 32'd0);
      check("rstm_mem", mem[4], 32'h12345678);
      txn(1'b1, 1'b0, 32'h80020010, 2'b10, 32'h0, lat, rd, er);
      check("rstm_fetch", rd, 32'h12345678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
